pe_clk_gate_ctrl: RTL and testbench

//  Per-PE clock-enable controller; sits directly upstream of the PE clock-gating cell and drives its enable.

---
 rtl/pe_clk_gate_ctrl.sv | 132 +++++++++++++
 tb/tb_pe_clk_gate_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_clk_gate_ctrl.sv
// pe_clk_gate_ctrl
//   Clock-enable controller for one PE. It sits directly upstream of the PE
//   clock-gating cell and drives its enable. When the PE has been idle for
//   IDLE_THRESHOLD consecutive cycles, the controller gates the clock off. Any
//   new activity, or gating_en going low, reopens the clock. pe_ready then
//   stays low for WAKE_CYCLES cycles while the gated clock settles. The number
//   of cycles spent asleep is counted for power statistics.
//
// Ports
//   clk           free-running (ungated) clock
//   reset         asynchronous, active-high
//   gating_en     1 = gating allowed, 0 = PE clock forced on
//   ifmap_valid   ifmap FIFO holds data
//   filter_valid  filter FIFO holds data
//   psum_in_valid incoming psum valid
//   pe_busy       PE MAC pipeline/control not idle
//   stat_clear    synchronous clear of gated_cycles
//   gate_enable   enable to the clock-gating cell (registered)
//   pe_ready      PE clock stable
//   sleeping      1 while in SLEEP
//   gated_cycles  saturating count of cycles spent in SLEEP
//   state_dbg     current FSM state (ACTIVE=0, SLEEP=1, WAKE=2)
//
// Handshake: pe_ready acts as a ready toward upstream issuers. A transfer to
// this PE may occur only on a cycle where the issuer's valid and pe_ready are
// both high. pe_ready never depends combinationally on any input. pe_ready
// high always implies gate_enable high.
module pe_clk_gate_ctrl #(
  parameter int IDLE_THRESHOLD = 8,
  parameter int WAKE_CYCLES    = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gating_en,
  input  logic                 ifmap_valid,
  input  logic                 filter_valid,
  input  logic                 psum_in_valid,
  input  logic                 pe_busy,
  input  logic                 stat_clear,
  output logic                 gate_enable,
  output logic                 pe_ready,
  output logic                 sleeping,
  output logic [CNT_WIDTH-1:0] gated_cycles,
  output logic [1:0]           state_dbg
);

  localparam int IDLE_W = (IDLE_THRESHOLD > 1) ? $clog2(IDLE_THRESHOLD) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_THRESHOLD - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } state_t;

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              activity;
  logic              stay_on;

  assign activity  = ifmap_valid | filter_valid | psum_in_valid | pe_busy;
  // Activity and a disabled gating policy both keep the clock running.
  assign stay_on   = activity | ~gating_en;
  assign state_dbg = state;

  // Every output is a flop that changes only on the rising clk edge. This keeps
  // gate_enable glitch-free into the low-phase latch of the gating cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACTIVE;
      gate_enable  <= 1'b1;
      pe_ready     <= 1'b1;
      sleeping     <= 1'b0;
      idle_cnt     <= '0;
      wake_cnt     <= '0;
      gated_cycles <= '0;
    end else begin
      // Statistics counter. A clear wins over a same-cycle increment.
      if (stat_clear) begin
        gated_cycles <= '0;
      end else if ((state == SLEEP) && (gated_cycles != {CNT_WIDTH{1'b1}})) begin
        gated_cycles <= gated_cycles + CNT_WIDTH'(1);
      end

      case (state)
        ACTIVE: begin
          if (stay_on) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state       <= SLEEP;
            gate_enable <= 1'b0;
            pe_ready    <= 1'b0;
            sleeping    <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        SLEEP: begin
          if (stay_on) begin
            state       <= WAKE;
            gate_enable <= 1'b1;
            sleeping    <= 1'b0;
            wake_cnt    <= '0;
          end
        end
        WAKE: begin
          // The settle window always runs to completion, whatever the inputs do.
          if (wake_cnt == WAKE_LAST) begin
            state    <= ACTIVE;
            pe_ready <= 1'b1;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + WAKE_W'(1);
          end
        end
        default: begin
          state       <= ACTIVE;
          gate_enable <= 1'b1;
          pe_ready    <= 1'b1;
          sleeping    <= 1'b0;
          idle_cnt    <= '0;
          wake_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_clk_gate_ctrl.sv
// tb_pe_clk_gate_ctrl
//   Self-checking bench for pe_clk_gate_ctrl with IDLE_THRESHOLD=4,
//   WAKE_CYCLES=2 and CNT_WIDTH=4. The driver applies one cycle of inputs on
//   each falling edge. A behavioural model then predicts the outputs after the
//   next rising edge and pushes them into exp_q. A separate monitor pops exp_q
//   one time unit after each rising edge and compares it with the DUT.
module tb_pe_clk_gate_ctrl;

  localparam int TH = 4;
  localparam int WC = 2;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam int EW = 3 + CW;

  logic          clk;
  logic          reset;
  logic          gating_en;
  logic          ifmap_valid;
  logic          filter_valid;
  logic          psum_in_valid;
  logic          pe_busy;
  logic          stat_clear;
  logic          gate_enable;
  logic          pe_ready;
  logic          sleeping;
  logic [CW-1:0] gated_cycles;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  // Each entry packs {gate_enable, pe_ready, sleeping, gated_cycles}.
  logic [EW-1:0] exp_q[$];

  // Behavioural model state.
  bit m_asleep;
  int m_wake_left;
  int m_idle_run;
  int m_gated;

  pe_clk_gate_ctrl #(
    .IDLE_THRESHOLD(TH),
    .WAKE_CYCLES   (WC),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .gating_en    (gating_en),
    .ifmap_valid  (ifmap_valid),
    .filter_valid (filter_valid),
    .psum_in_valid(psum_in_valid),
    .pe_busy      (pe_busy),
    .stat_clear   (stat_clear),
    .gate_enable  (gate_enable),
    .pe_ready     (pe_ready),
    .sleeping     (sleeping),
    .gated_cycles (gated_cycles),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model
  function automatic logic [EW-1:0] model_outputs();
    logic ge;
    logic rdy;
    ge  = !m_asleep;
    rdy = !m_asleep && (m_wake_left == 0);
    return {ge, rdy, m_asleep, CW'(m_gated)};
  endfunction

  task automatic model_reset();
    m_asleep    = 1'b0;
    m_wake_left = 0;
    m_idle_run  = 0;
    m_gated     = 0;
  endtask

  // Advances the model by one clock edge.
  task automatic model_step(input bit act, input bit gen, input bit clr);
    bit on;
    on = act || !gen;
    if (clr) m_gated = 0;
    else if (m_asleep && m_gated < SAT) m_gated = m_gated + 1;
    if (m_wake_left > 0) begin
      m_wake_left = m_wake_left - 1;
      if (m_wake_left == 0) m_idle_run = 0;
    end else if (m_asleep) begin
      if (on) begin
        m_asleep    = 1'b0;
        m_wake_left = WC;
      end
    end else if (on) begin
      m_idle_run = 0;
    end else begin
      m_idle_run = m_idle_run + 1;
      if (m_idle_run == TH) begin
        m_asleep   = 1'b1;
        m_idle_run = 0;
      end
    end
  endtask

  // Driver: one cycle of stimulus.
  // act_sel: bit0 ifmap, bit1 filter, bit2 psum, bit3 busy.
  task automatic step(input bit rst, input bit gen, input logic [3:0] act_sel,
                      input bit clr);
    @(negedge clk);
    reset         = rst;
    gating_en     = gen;
    ifmap_valid   = act_sel[0];
    filter_valid  = act_sel[1];
    psum_in_valid = act_sel[2];
    pe_busy       = act_sel[3];
    stat_clear    = clr;
    if (rst) model_reset();
    else model_step(act_sel != 4'd0, gen, clr);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'd0, 1'b0);
  endtask

  task automatic check1(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check1("gate_enable", 32'(gate_enable), 32'(e[EW-1]));
      check1("pe_ready", 32'(pe_ready), 32'(e[EW-2]));
      check1("sleeping", 32'(sleeping), 32'(e[EW-3]));
      check1("gated_cycles", 32'(gated_cycles), 32'(e[CW-1:0]));
    end
    check1("ready_implies_enable", 32'(pe_ready && !gate_enable), 32'd0);
  end

  // Asserts reset between edges and checks the outputs before any edge occurs.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check1("async_rst_gate_enable", 32'(gate_enable), 32'd1);
    check1("async_rst_pe_ready", 32'(pe_ready), 32'd1);
    check1("async_rst_sleeping", 32'(sleeping), 32'd0);
    check1("async_rst_gated_cycles", 32'(gated_cycles), 32'd0);
    model_reset();
  endtask

  // Stimulus
  initial begin
    reset = 1'b1; gating_en = 1'b1; ifmap_valid = 1'b0; filter_valid = 1'b0;
    psum_in_valid = 1'b0; pe_busy = 1'b0; stat_clear = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'd0, 1'b0);

    // Gating after four idle cycles, then further sleep.
    idle(6);
    // A busy pulse wakes the PE. Inputs are ignored during WAKE.
    step(1'b0, 1'b1, 4'b1000, 1'b0);
    step(1'b0, 1'b0, 4'b0001, 1'b0);
    idle(1);
    // Activity on the threshold cycle restarts the idle count.
    idle(3);
    step(1'b0, 1'b1, 4'b0001, 1'b0);
    idle(6);
    // Long sleep saturates the counter. A clear during an increment wins.
    idle(20);
    step(1'b0, 1'b1, 4'd0, 1'b1);
    idle(3);
    // A forced-on clock never gates. Dropping gating_en in SLEEP wakes the PE.
    step(1'b0, 1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    idle(6);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    // Async reset in the middle of WAKE.
    idle(7);
    step(1'b0, 1'b1, 4'b0010, 1'b0);
    async_reset_check();
    step(1'b1, 1'b1, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0);

    // Random traffic with sparse activity so that sleeps happen often.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] a;
      bit g;
      bit c;
      for (int b = 0; b < 4; b++) a[b] = ($urandom_range(0, 11) == 0);
      g = ($urandom_range(0, 15) != 0);
      c = ($urandom_range(0, 30) == 0);
      step(1'b0, g, a, c);
    end

    @(posedge clk);
    #3;
    check1("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
